regfile_dump_unit: RTL and testbench
====================================

# regfile_dump_unit

Run controller and register-file drain for the single-cycle RISC-V CPU in simulation and FPGA bring-up. On `start` it lets the CPU execute for a fixed number of clock cycles, then asserts `cpu_halt`. It reads the CPU register file one index at a time and streams each `(index, value)` pair out over a valid/ready port to a checker or UART bridge. It sits directly downstream of the CPU's register file, on a dedicated debug read port.

## Interface
- `RUN_CYCLES`, 100: cycles the CPU runs before halt; legal range 1..2^32-1.
- `SETTLE_CYCLES`, 2: cycles between halt and first register read, letting in-flight writebacks land; minimum 1.
- `NUM_REGS`, 32: registers drained, indices 0..NUM_REGS-1.
- `XLEN`, 32: register width.
- `IDX_W`, 5: index width; must satisfy 2^IDX_W >= NUM_REGS.

Ports:
- `clk` in 1: single clock; all state changes on its rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: single-cycle pulse that begins a run.
- `cpu_halt` out 1: freezes CPU state (PC and register writes) while high.
- `rf_raddr` out IDX_W: debug read address into the CPU register file.
- `rf_rdata` in XLEN: combinational read data for `rf_raddr`.
- `dump_valid` out 1: dump beat valid.
- `dump_ready` in 1: consumer accepts the beat.
- `dump_idx` out IDX_W: register index of the current beat.
- `dump_data` out XLEN: register value of the current beat.
- `done` out 1: all NUM_REGS beats accepted.
- `cycle_count` out 32: CPU cycles executed in the current or last run.

## Operation
- States: IDLE, RUN, SETTLE, READ, EMIT, DONE.
- Reset, on any edge with `reset`=1:
  - state goes to IDLE.
  - Every output is 0, including `cpu_halt`, `dump_valid`, `done`, `cycle_count`, `rf_raddr`, `dump_idx` and `dump_data`.
  - `reset` overrides `start` in the same cycle.
- IDLE:
  - `start`=1 moves to RUN.
  - `cycle_count` is cleared to 0.
- RUN:
  - `cycle_count` increments by 1 each cycle.
  - On the edge where `cycle_count` == RUN_CYCLES-1, `cycle_count` becomes RUN_CYCLES, `cpu_halt` is set to 1, and the settle counter loads SETTLE_CYCLES. State moves to SETTLE.
- SETTLE:
  - The settle counter decrements each cycle.
  - When it reaches 1, the index register is cleared to 0 and state moves to READ.
- READ, one cycle:
  - `rf_raddr` = index.
  - At the edge, `rf_rdata` is registered into `dump_data`, index into `dump_idx`, `dump_valid` is set to 1, and state moves to EMIT.
- EMIT:
  - `dump_valid`, `dump_idx` and `dump_data` are held stable until `dump_valid && dump_ready`.
  - Changes on `rf_rdata` during EMIT are ignored.
  - On handshake, `dump_valid` drops to 0.
  - If index == NUM_REGS-1, state moves to DONE. Otherwise index increments and state moves to READ.
- DONE:
  - `done`=1 and `cpu_halt`=1 are held; `cycle_count` is frozen.
  - `start`=1 returns to RUN with `cycle_count` cleared, `cpu_halt` cleared and `done` cleared on that same edge.
- `start` is ignored in RUN, SETTLE, READ and EMIT.
- `cpu_halt` stays 1 from the halt edge through SETTLE, READ, EMIT and DONE.
- `cycle_count` never wraps, because RUN_CYCLES is at most 2^32-1.

## Timing
- Take `start` sampled high at edge E.
  - RUN spans the cycles after edges E .. E+RUN_CYCLES-1.
  - `cpu_halt` rises at edge E+RUN_CYCLES, so the CPU executes exactly RUN_CYCLES cycles.
  - The first READ cycle begins after edge E+RUN_CYCLES+SETTLE_CYCLES.
  - The first `dump_valid` rises one edge later.
- Each beat costs 1 READ cycle plus at least 1 EMIT cycle. With `dump_ready` tied high that is 2 cycles per beat, and `done` rises 2*NUM_REGS edges after the first READ starts.
- `rf_raddr` is registered and stable for the whole READ cycle. `rf_rdata` is sampled only at the end of READ.
- The block has no combinational path from `dump_ready` to any output.

## Test plan
- **Nominal run**
  - Stimulus: defaults; register file model with reg[i] = 32'h1000_0000 + i; `dump_ready`=1; `start` at edge 5.
  - Required response:
    - `cpu_halt` rises at edge 105.
    - First `dump_valid` rises at edge 108 with idx 0 and data 32'h1000_0000.
    - 32 beats arrive in order, idx 0..31, each with its matching data.
    - `done` rises at edge 171.
    - `cycle_count` = 100.
- **Backpressure**
  - Stimulus: `dump_ready` held low for 7 cycles while idx 3 is presented; `rf_rdata` for index 3 changed to 32'hDEAD_BEEF during the stall.
  - Required response: idx 3 and its original data stay stable for the whole stall; no index is skipped or duplicated.
- **Reset during drain**
  - Stimulus: `reset` asserted for 1 cycle while EMIT is presenting idx 17.
  - Required response:
    - The next cycle shows all outputs at 0 and the block is in IDLE.
    - A new `start` begins a fresh run with `cycle_count` from 0 and the drain from idx 0.
- **Start handling**
  - Stimulus: `start` pulses during RUN and during EMIT; then `start` pulses in DONE.
  - Required response:
    - The pulses in RUN and EMIT change nothing, and halt timing is unchanged.
    - The pulse in DONE clears `done` and `cpu_halt` and runs a second full cycle-count plus drain sequence.
- **Reset versus start**
  - Stimulus: `reset` and `start` high on the same edge.
  - Required response: the block stays in IDLE and `cycle_count` remains 0.
- **Parameter corner**
  - Stimulus: RUN_CYCLES=1, SETTLE_CYCLES=1, NUM_REGS=4, IDX_W=2.
  - Required response:
    - `cpu_halt` rises 1 edge after `start`.
    - 4 beats arrive, idx 0..3.
    - `done` follows the last handshake by exactly 1 edge.

Source files
------------

// File: rtl/regfile_dump_unit.sv
// regfile_dump_unit: runs the CPU for RUN_CYCLES cycles, halts it, waits SETTLE_CYCLES,
// then streams every register (index, value) pair out over a valid/ready port.
// Ports: clk/reset (sync, active-high); start pulse; cpu_halt freezes the CPU;
//   rf_raddr/rf_rdata debug read port; dump_valid/dump_ready/dump_idx/dump_data stream;
//   done after the last beat is accepted; cycle_count = CPU cycles run in this/last run.
module regfile_dump_unit #(
  parameter int unsigned RUN_CYCLES    = 100,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned NUM_REGS      = 32,
  parameter int unsigned XLEN          = 32,
  parameter int unsigned IDX_W         = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             cpu_halt,
  output logic [IDX_W-1:0] rf_raddr,
  input  logic [XLEN-1:0]  rf_rdata,
  output logic             dump_valid,
  input  logic             dump_ready,
  output logic [IDX_W-1:0] dump_idx,
  output logic [XLEN-1:0]  dump_data,
  output logic             done,
  output logic [31:0]      cycle_count
);

  localparam int unsigned      SET_W    = $clog2(SETTLE_CYCLES + 1);
  localparam logic [31:0]      RUN_LAST = 32'(RUN_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REGS - 1);
  localparam logic [SET_W-1:0] SET_LOAD = SET_W'(SETTLE_CYCLES);
  localparam logic [SET_W-1:0] SET_ONE  = SET_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_SETTLE,
    S_READ,
    S_EMIT,
    S_DONE
  } state_t;

  state_t           state;
  logic [SET_W-1:0] settle_cnt;

  // rf_raddr doubles as the drain index: it is registered, so it is already
  // stable for the whole READ cycle, and dump_idx copies it at the READ edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      settle_cnt  <= '0;
      cpu_halt    <= 1'b0;
      rf_raddr    <= '0;
      dump_valid  <= 1'b0;
      dump_idx    <= '0;
      dump_data   <= '0;
      done        <= 1'b0;
      cycle_count <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          cycle_count <= '0;
          if (start) state <= S_RUN;
        end
        S_RUN: begin
          cycle_count <= cycle_count + 32'd1;
          // Halt lands on the edge that completes the last CPU cycle.
          if (cycle_count == RUN_LAST) begin
            cpu_halt   <= 1'b1;
            settle_cnt <= SET_LOAD;
            state      <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (settle_cnt == SET_ONE) begin
            rf_raddr <= '0;
            state    <= S_READ;
          end else begin
            settle_cnt <= settle_cnt - SET_ONE;
          end
        end
        S_READ: begin
          dump_data  <= rf_rdata;
          dump_idx   <= rf_raddr;
          dump_valid <= 1'b1;
          state      <= S_EMIT;
        end
        S_EMIT: begin
          // dump_valid is always high here, so ready alone completes the beat.
          if (dump_ready) begin
            dump_valid <= 1'b0;
            if (rf_raddr == IDX_LAST) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              rf_raddr <= rf_raddr + IDX_W'(1);
              state    <= S_READ;
            end
          end
        end
        S_DONE: begin
          if (start) begin
            cycle_count <= '0;
            cpu_halt    <= 1'b0;
            done        <= 1'b0;
            state       <= S_RUN;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump_unit.sv
// Bench for regfile_dump_unit: a table-driven nominal run, randomized drains checked
// against a cycle-level behavioural model, and hand-written corner sequences.
// Instance a uses default parameters; instance b uses the minimal parameter corner.
module tb_regfile_dump_unit;

  localparam int RUN_A = 100;
  localparam int SET_A = 2;
  localparam int NUM_A = 32;
  localparam int NUM_B = 4;

  logic clk;
  logic reset;

  // instance a
  logic        start_a, ready_a, halt_a, valid_a, done_a;
  logic [4:0]  raddr_a, idx_a;
  logic [31:0] rdata_a, data_a, cc_a;
  logic [31:0] regs_a [NUM_A];

  // instance b
  logic        start_b, ready_b, halt_b, valid_b, done_b;
  logic [1:0]  raddr_b, idx_b;
  logic [31:0] rdata_b, data_b, cc_b;
  logic [31:0] regs_b [NUM_B];

  int n_checks;
  int n_err;

  assign rdata_a = regs_a[raddr_a];
  assign rdata_b = regs_b[raddr_b];

  regfile_dump_unit #(
    .RUN_CYCLES(RUN_A), .SETTLE_CYCLES(SET_A), .NUM_REGS(NUM_A), .XLEN(32), .IDX_W(5)
  ) u_dut_a (
    .clk(clk), .reset(reset), .start(start_a), .cpu_halt(halt_a),
    .rf_raddr(raddr_a), .rf_rdata(rdata_a),
    .dump_valid(valid_a), .dump_ready(ready_a), .dump_idx(idx_a), .dump_data(data_a),
    .done(done_a), .cycle_count(cc_a)
  );

  regfile_dump_unit #(
    .RUN_CYCLES(1), .SETTLE_CYCLES(1), .NUM_REGS(NUM_B), .XLEN(32), .IDX_W(2)
  ) u_dut_b (
    .clk(clk), .reset(reset), .start(start_b), .cpu_halt(halt_b),
    .rf_raddr(raddr_b), .rf_rdata(rdata_b),
    .dump_valid(valid_b), .dump_ready(ready_b), .dump_idx(idx_b), .dump_data(data_b),
    .done(done_b), .cycle_count(cc_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock edge; outputs are sampled 1 time unit after it, and start is a pulse.
  task automatic step();
    @(posedge clk);
    #1;
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic chk_zero_a(input string tag);
    chk({tag, "_halt"},  64'(halt_a),  64'(0));
    chk({tag, "_valid"}, 64'(valid_a), 64'(0));
    chk({tag, "_done"},  64'(done_a),  64'(0));
    chk({tag, "_cc"},    64'(cc_a),    64'(0));
    chk({tag, "_raddr"}, 64'(raddr_a), 64'(0));
    chk({tag, "_idx"},   64'(idx_a),   64'(0));
    chk({tag, "_data"},  64'(data_a),  64'(0));
  endtask

  // Behavioural model of one run on instance a, starting with a start pulse.
  // Rules: CPU runs RUN_A cycles, halts, first read SET_A cycles later; each beat is
  // one read cycle (valid low, raddr = beat) then presented until accepted; beats
  // carry the register values as they were when the run began.
  task automatic drain_run(input int stall_idx, input int stall_len,
                           input int reset_idx, input bit rand_rdy);
    logic [31:0] exp_data [NUM_A];
    int  k;
    int  stall_left;
    bit  hs, exp_valid, exp_done, exp_read, finished;
    for (int i = 0; i < NUM_A; i++) begin
      regs_a[i]   = $urandom;
      exp_data[i] = regs_a[i];
    end
    k = 0;
    hs = 1'b0;
    stall_left = stall_len;
    finished = 1'b0;
    ready_a = 1'b0;
    start_a = 1'b1;
    for (int rel = 0; rel < 4000 && !finished; rel++) begin
      step();
      if (hs) k++;
      exp_done  = (k == NUM_A);
      exp_valid = (rel > RUN_A + SET_A) && !hs && !exp_done;
      exp_read  = !exp_done && ((rel == RUN_A + SET_A) || hs);
      chk("run_halt",  64'(halt_a),  64'(rel >= RUN_A));
      chk("run_cc",    64'(cc_a),    64'((rel >= RUN_A) ? RUN_A : rel));
      chk("run_done",  64'(done_a),  64'(exp_done));
      chk("run_valid", 64'(valid_a), 64'(exp_valid));
      if (exp_valid) begin
        chk("beat_idx",  64'(idx_a),  64'(k));
        chk("beat_data", 64'(data_a), 64'(exp_data[k]));
      end
      if (exp_read) chk("read_raddr", 64'(raddr_a), 64'(k));
      if (exp_done) begin
        finished = 1'b1;
      end else begin
        if (reset_idx >= 0 && exp_valid && k == reset_idx) begin
          reset = 1'b1;
          step();
          reset = 1'b0;
          ready_a = 1'b1;
          chk_zero_a("drain_reset");
          return;
        end
        if (exp_valid && k == stall_idx && stall_left > 0) begin
          // Register changes after its read must not reach the held beat.
          if (stall_left == stall_len) regs_a[k] = 32'hDEAD_BEEF;
          ready_a = 1'b0;
          stall_left--;
        end else if (rand_rdy) begin
          ready_a = ($urandom_range(0, 3) != 0);
        end else begin
          ready_a = 1'b1;
        end
        hs = exp_valid && ready_a;
        // Stray start pulses while busy must be ignored.
        if ($urandom_range(0, 19) == 0) start_a = 1'b1;
      end
    end
    if (!finished) chk("drain_timeout", 64'(0), 64'(1));
  endtask

  typedef struct {
    int d;      // sample point: edges after the start edge
    bit start;  // inputs applied for the following edge
    bit ready;
    bit halt;   // expected outputs
    bit valid;
    bit done;
    int cc;
    int idx;    // -1: not checked; otherwise idx and data 32'h1000_0000+idx
    int raddr;  // -1: not checked
  } vec_t;

  initial begin
    vec_t vecs [15];
    int   rel;
    vecs[0]  = '{0,   0, 1, 0, 0, 0, 0,   -1, -1};
    vecs[1]  = '{1,   0, 1, 0, 0, 0, 1,   -1, -1};
    vecs[2]  = '{50,  1, 1, 0, 0, 0, 50,  -1, -1};
    vecs[3]  = '{51,  0, 1, 0, 0, 0, 51,  -1, -1};
    vecs[4]  = '{99,  0, 1, 0, 0, 0, 99,  -1, -1};
    vecs[5]  = '{100, 0, 1, 1, 0, 0, 100, -1, -1};
    vecs[6]  = '{101, 0, 1, 1, 0, 0, 100, -1, -1};
    vecs[7]  = '{102, 0, 1, 1, 0, 0, 100, -1, 0};
    vecs[8]  = '{103, 1, 1, 1, 1, 0, 100, 0,  -1};
    vecs[9]  = '{104, 0, 1, 1, 0, 0, 100, -1, 1};
    vecs[10] = '{105, 0, 1, 1, 1, 0, 100, 1,  -1};
    vecs[11] = '{121, 0, 1, 1, 1, 0, 100, 9,  -1};
    vecs[12] = '{165, 0, 1, 1, 1, 0, 100, 31, -1};
    vecs[13] = '{166, 0, 1, 1, 0, 1, 100, -1, -1};
    vecs[14] = '{170, 0, 1, 1, 0, 1, 100, -1, -1};

    n_checks = 0;
    n_err    = 0;
    reset    = 1'b1;
    start_a  = 1'b0;
    ready_a  = 1'b1;
    start_b  = 1'b0;
    ready_b  = 1'b1;
    for (int i = 0; i < NUM_A; i++) regs_a[i] = 32'h1000_0000 + 32'(i);
    for (int i = 0; i < NUM_B; i++) regs_b[i] = 32'h0000_0B00 + 32'(i);

    // Reset state
    step();
    step();
    reset = 1'b0;
    chk_zero_a("reset");
    step();
    step();
    chk("idle_cc", 64'(cc_a), 64'(0));

    // Nominal run from the table; start is sampled on edge 5.
    rel = -1;
    start_a = 1'b1;
    for (int v = 0; v < 15; v++) begin
      while (rel < vecs[v].d) begin
        step();
        rel++;
      end
      chk("nom_halt",  64'(halt_a),  64'(vecs[v].halt));
      chk("nom_valid", 64'(valid_a), 64'(vecs[v].valid));
      chk("nom_done",  64'(done_a),  64'(vecs[v].done));
      chk("nom_cc",    64'(cc_a),    64'(vecs[v].cc));
      if (vecs[v].idx >= 0) begin
        chk("nom_idx",  64'(idx_a),  64'(vecs[v].idx));
        chk("nom_data", 64'(data_a), 64'(32'h1000_0000 + 32'(vecs[v].idx)));
      end
      if (vecs[v].raddr >= 0) chk("nom_raddr", 64'(raddr_a), 64'(vecs[v].raddr));
      start_a = vecs[v].start;
      ready_a = vecs[v].ready;
    end

    // Restart from DONE with a 7-cycle stall on beat 3.
    drain_run(3, 7, -1, 1'b0);

    // Reset while beat 17 is presented, then confirm the block sits in IDLE.
    drain_run(-1, 0, 17, 1'b1);
    step();
    step();
    chk("post_reset_cc",    64'(cc_a),    64'(0));
    chk("post_reset_halt",  64'(halt_a),  64'(0));
    chk("post_reset_valid", 64'(valid_a), 64'(0));

    // Fresh randomized run after the reset.
    drain_run(-1, 0, -1, 1'b1);

    // Reset and start on the same edge (block is in DONE beforehand).
    reset   = 1'b1;
    start_a = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_start_cc",   64'(cc_a),   64'(0));
    chk("rst_start_halt", 64'(halt_a), 64'(0));
    chk("rst_start_done", 64'(done_a), 64'(0));
    step();
    step();
    chk("rst_start_idle_cc", 64'(cc_a), 64'(0));

    // Parameter corner on instance b: RUN=1, SETTLE=1, four registers.
    ready_b = 1'b1;
    start_b = 1'b1;
    step();
    chk("b_cc0",   64'(cc_b),   64'(0));
    chk("b_halt0", 64'(halt_b), 64'(0));
    step();
    chk("b_halt1", 64'(halt_b), 64'(1));
    chk("b_cc1",   64'(cc_b),   64'(1));
    step();
    chk("b_read_valid", 64'(valid_b), 64'(0));
    chk("b_read_raddr", 64'(raddr_b), 64'(0));
    for (int k = 0; k < NUM_B; k++) begin
      step();
      chk("b_valid", 64'(valid_b), 64'(1));
      chk("b_idx",   64'(idx_b),   64'(k));
      chk("b_data",  64'(data_b),  64'(32'h0000_0B00 + 32'(k)));
      chk("b_done_early", 64'(done_b), 64'(0));
      step();
      chk("b_valid_low", 64'(valid_b), 64'(0));
      if (k < NUM_B - 1) chk("b_raddr", 64'(raddr_b), 64'(k + 1));
      else               chk("b_done",  64'(done_b),  64'(1));
    end
    chk("b_final_halt", 64'(halt_b), 64'(1));
    chk("b_final_cc",   64'(cc_b),   64'(1));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
